// File: rtl/alu_arbiter_if.sv
// Bus bundle between the two ALU requesters, the shared ALU and the result
// consumer. The arbiter sits on the slave modport; the surrounding datapath
// (requesters, ALU and consumer) uses the master modport.
interface alu_arbiter_if #(
    parameter int DATA_W = 16
);
    logic              req0_valid;
    logic              req0_ready;
    logic [DATA_W-1:0] req0_in1;
    logic [DATA_W-1:0] req0_in2;
    logic [2:0]        req0_op;
    logic [3:0]        req0_shift;
    logic              req0_setcc;

    logic              req1_valid;
    logic              req1_ready;
    logic [DATA_W-1:0] req1_in1;
    logic [DATA_W-1:0] req1_in2;
    logic [2:0]        req1_op;
    logic [3:0]        req1_shift;
    logic              req1_setcc;

    logic [DATA_W-1:0] alu_in1;
    logic [DATA_W-1:0] alu_in2;
    logic [2:0]        alu_op;
    logic [3:0]        alu_shift;
    logic [DATA_W-1:0] alu_out;

    logic              res_valid;
    logic              res_ready;
    logic [DATA_W-1:0] res_data;
    logic              res_id;
    logic [2:0]        nzp;

    modport slave (
        input  req0_valid, req0_in1, req0_in2, req0_op, req0_shift, req0_setcc,
        output req0_ready,
        input  req1_valid, req1_in1, req1_in2, req1_op, req1_shift, req1_setcc,
        output req1_ready,
        output alu_in1, alu_in2, alu_op, alu_shift,
        input  alu_out,
        output res_valid, res_data, res_id, nzp,
        input  res_ready
    );

    modport master (
        output req0_valid, req0_in1, req0_in2, req0_op, req0_shift, req0_setcc,
        input  req0_ready,
        output req1_valid, req1_in1, req1_in2, req1_op, req1_shift, req1_setcc,
        input  req1_ready,
        input  alu_in1, alu_in2, alu_op, alu_shift,
        output alu_out,
        input  res_valid, res_data, res_id, nzp,
        output res_ready
    );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational 16-bit ALU between the
// execute stage (requester 0) and the address/PC-increment unit (requester 1).
// The granted requester's operands drive the ALU directly; the result is
// captured in a one-entry valid/ready buffer and optionally updates NZP.
module alu_arbiter #(
    parameter int         DATA_W    = 16,
    parameter logic [2:0] RESET_NZP = 3'b010
) (
    input  logic       clk,
    input  logic       reset,
    alu_arbiter_if.slave bus
);
    logic              last_grant;
    logic              res_valid_q;
    logic [DATA_W-1:0] res_data_q;
    logic              res_id_q;
    logic [2:0]        nzp_q;

    logic              free;
    logic              pick1;
    logic              grant0;
    logic              grant1;
    logic              sel_setcc;
    logic [2:0]        nzp_next;

    // Arbitration: a lone requester wins, a tie goes to whoever did not win last
    always_comb begin
        free   = !res_valid_q || bus.res_ready;
        pick1  = bus.req1_valid && (!bus.req0_valid || (last_grant == 1'b0));
        grant1 = free && pick1;
        grant0 = free && bus.req0_valid && !pick1;
    end

    // Steer the granted requester's fields onto the ALU; idle drives zeros
    always_comb begin
        bus.alu_in1   = '0;
        bus.alu_in2   = '0;
        bus.alu_op    = 3'd0;
        bus.alu_shift = 4'd0;
        sel_setcc     = 1'b0;
        if (grant0) begin
            bus.alu_in1   = bus.req0_in1;
            bus.alu_in2   = bus.req0_in2;
            bus.alu_op    = bus.req0_op;
            bus.alu_shift = bus.req0_shift;
            sel_setcc     = bus.req0_setcc;
        end else if (grant1) begin
            bus.alu_in1   = bus.req1_in1;
            bus.alu_in2   = bus.req1_in2;
            bus.alu_op    = bus.req1_op;
            bus.alu_shift = bus.req1_shift;
            sel_setcc     = bus.req1_setcc;
        end
    end

    // Condition codes derived from the live ALU result (exactly one bit set)
    always_comb begin
        nzp_next[2] = bus.alu_out[DATA_W-1];
        nzp_next[1] = (bus.alu_out == '0);
        nzp_next[0] = !bus.alu_out[DATA_W-1] && (bus.alu_out != '0);
    end

    // Result buffer, round-robin pointer and NZP register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_id_q    <= 1'b0;
            nzp_q       <= RESET_NZP;
            last_grant  <= 1'b1;
        end else begin
            if (grant0 || grant1) begin
                res_valid_q <= 1'b1;
                res_data_q  <= bus.alu_out;
                res_id_q    <= grant1;
                last_grant  <= grant1;
                if (sel_setcc) begin
                    nzp_q <= nzp_next;
                end
            end else if (bus.res_ready) begin
                res_valid_q <= 1'b0;
            end
        end
    end

    assign bus.req0_ready = grant0;
    assign bus.req1_ready = grant1;
    assign bus.res_valid  = res_valid_q;
    assign bus.res_data   = res_data_q;
    assign bus.res_id     = res_id_q;
    assign bus.nzp        = nzp_q;
endmodule

// File: tb/tb_alu_arbiter.sv
// Testbench for alu_arbiter: a behavioural ALU closes the loop, a table of
// single-requester operations checks data, id and NZP, and hand-written
// sequences cover fairness, backpressure, drain, turn retention and reset.
module tb_alu_arbiter;
    logic clk;
    logic reset;
    int   compared;
    int   mismatched;

    typedef struct {
        logic        rid;
        logic [2:0]  op;
        logic [15:0] in1;
        logic [15:0] in2;
        logic [3:0]  sh;
        logic        setcc;
        logic [15:0] exp_data;
        logic [2:0]  exp_nzp;
    } vec_t;

    vec_t vecs[9];

    alu_arbiter_if #(.DATA_W(16)) bus();

    alu_arbiter #(.DATA_W(16), .RESET_NZP(3'b010)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    // Reference ALU: combinational from the arbiter's alu_* drive
    always_comb begin
        case (bus.alu_op)
            3'd0:    bus.alu_out = bus.alu_in1 + bus.alu_in2;
            3'd1:    bus.alu_out = bus.alu_in1 & bus.alu_in2;
            3'd2:    bus.alu_out = ~bus.alu_in1;
            3'd3:    bus.alu_out = bus.alu_in1 ^ bus.alu_in2;
            3'd4:    bus.alu_out = bus.alu_in1 << bus.alu_shift;
            3'd5:    bus.alu_out = bus.alu_in1 >> bus.alu_shift;
            3'd6:    bus.alu_out = 16'($signed(bus.alu_in1) >>> bus.alu_shift);
            default: bus.alu_out = 16'h0000;
        endcase
    end

    // Free-running clock, 10 time units per cycle
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic rid, input logic [2:0] op, input logic [15:0] in1,
                                 input logic [15:0] in2, input logic [3:0] sh, input logic setcc);
        if (rid == 1'b0) begin
            bus.req0_valid = 1'b1;
            bus.req0_op    = op;
            bus.req0_in1   = in1;
            bus.req0_in2   = in2;
            bus.req0_shift = sh;
            bus.req0_setcc = setcc;
        end else begin
            bus.req1_valid = 1'b1;
            bus.req1_op    = op;
            bus.req1_in1   = in1;
            bus.req1_in2   = in2;
            bus.req1_shift = sh;
            bus.req1_setcc = setcc;
        end
    endtask

    task automatic clearReq(input logic rid);
        if (rid == 1'b0) begin
            bus.req0_valid = 1'b0;
            bus.req0_op    = 3'd0;
            bus.req0_in1   = 16'h0;
            bus.req0_in2   = 16'h0;
            bus.req0_shift = 4'd0;
            bus.req0_setcc = 1'b0;
        end else begin
            bus.req1_valid = 1'b0;
            bus.req1_op    = 3'd0;
            bus.req1_in1   = 16'h0;
            bus.req1_in2   = 16'h0;
            bus.req1_shift = 4'd0;
            bus.req1_setcc = 1'b0;
        end
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;

        //        rid   op    in1       in2       sh     setcc  data      nzp
        vecs[0] = '{1'b0, 3'd0, 16'h0003, 16'h0004, 4'd0,  1'b1, 16'h0007, 3'b001};
        vecs[1] = '{1'b1, 3'd6, 16'h8000, 16'h0000, 4'd4,  1'b1, 16'hF800, 3'b100};
        vecs[2] = '{1'b0, 3'd1, 16'h00F0, 16'h0F00, 4'd0,  1'b0, 16'h0000, 3'b100};
        vecs[3] = '{1'b0, 3'd7, 16'h1234, 16'h5678, 4'd3,  1'b1, 16'h0000, 3'b010};
        vecs[4] = '{1'b1, 3'd4, 16'h0001, 16'h0000, 4'd15, 1'b1, 16'h8000, 3'b100};
        vecs[5] = '{1'b0, 3'd5, 16'h8000, 16'h0000, 4'd4,  1'b1, 16'h0800, 3'b001};
        vecs[6] = '{1'b1, 3'd3, 16'h1234, 16'h1234, 4'd0,  1'b1, 16'h0000, 3'b010};
        vecs[7] = '{1'b0, 3'd0, 16'h7FFF, 16'h0001, 4'd0,  1'b1, 16'h8000, 3'b100};
        vecs[8] = '{1'b1, 3'd2, 16'h00FF, 16'h0000, 4'd0,  1'b0, 16'hFF00, 3'b100};

        reset = 1'b0;
        bus.res_ready = 1'b0;
        clearReq(1'b0);
        clearReq(1'b1);

        // Reset state
        #12;
        checkOutput("reset res_valid", bus.res_valid, 16'h0);
        checkOutput("reset res_data", bus.res_data, 16'h0);
        checkOutput("reset res_id", bus.res_id, 16'h0);
        checkOutput("reset nzp", bus.nzp, 16'h2);
        #5 reset = 1'b1;
        @(posedge clk); #1;

        // Table of single-requester operations with the consumer always ready
        bus.res_ready = 1'b1;
        for (int i = 0; i < 9; i++) begin
            applyStimulus(vecs[i].rid, vecs[i].op, vecs[i].in1, vecs[i].in2, vecs[i].sh, vecs[i].setcc);
            #1;
            checkOutput($sformatf("v%0d req0_ready", i), bus.req0_ready, (vecs[i].rid == 1'b0) ? 16'h1 : 16'h0);
            checkOutput($sformatf("v%0d req1_ready", i), bus.req1_ready, (vecs[i].rid == 1'b1) ? 16'h1 : 16'h0);
            checkOutput($sformatf("v%0d alu_in1", i), bus.alu_in1, vecs[i].in1);
            @(posedge clk); #1;
            checkOutput($sformatf("v%0d res_valid", i), bus.res_valid, 16'h1);
            checkOutput($sformatf("v%0d res_data", i), bus.res_data, vecs[i].exp_data);
            checkOutput($sformatf("v%0d res_id", i), bus.res_id, {15'h0, vecs[i].rid});
            checkOutput($sformatf("v%0d nzp", i), bus.nzp, {13'h0, vecs[i].exp_nzp});
            clearReq(vecs[i].rid);
        end

        // Fairness: both held valid, last winner was requester 1 so 0 goes first
        applyStimulus(1'b0, 3'd3, 16'hFFFF, 16'h00FF, 4'd0, 1'b0);
        applyStimulus(1'b1, 3'd2, 16'h0000, 16'h0000, 4'd0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            #1;
            checkOutput($sformatf("rr%0d req0_ready", i), bus.req0_ready, (i % 2 == 0) ? 16'h1 : 16'h0);
            checkOutput($sformatf("rr%0d req1_ready", i), bus.req1_ready, (i % 2 == 1) ? 16'h1 : 16'h0);
            @(posedge clk); #1;
            checkOutput($sformatf("rr%0d res_valid", i), bus.res_valid, 16'h1);
            checkOutput($sformatf("rr%0d res_id", i), bus.res_id, (i % 2 == 0) ? 16'h0 : 16'h1);
            checkOutput($sformatf("rr%0d res_data", i), bus.res_data, (i % 2 == 0) ? 16'hFF00 : 16'hFFFF);
            checkOutput($sformatf("rr%0d nzp", i), bus.nzp, 16'h4);
        end
        clearReq(1'b0);
        clearReq(1'b1);

        // Backpressure: buffer full, consumer stalled, requester 1 waiting
        bus.res_ready = 1'b0;
        applyStimulus(1'b1, 3'd0, 16'h1111, 16'h2222, 4'd0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            #1;
            checkOutput($sformatf("bp%0d req1_ready", i), bus.req1_ready, 16'h0);
            checkOutput($sformatf("bp%0d req0_ready", i), bus.req0_ready, 16'h0);
            @(posedge clk); #1;
            checkOutput($sformatf("bp%0d res_valid", i), bus.res_valid, 16'h1);
            checkOutput($sformatf("bp%0d res_data", i), bus.res_data, 16'hFFFF);
            checkOutput($sformatf("bp%0d res_id", i), bus.res_id, 16'h1);
        end
        // Drain and refill in the same cycle
        bus.res_ready = 1'b1;
        #1;
        checkOutput("refill req1_ready", bus.req1_ready, 16'h1);
        @(posedge clk); #1;
        checkOutput("refill res_valid", bus.res_valid, 16'h1);
        checkOutput("refill res_data", bus.res_data, 16'h3333);
        checkOutput("refill res_id", bus.res_id, 16'h1);
        clearReq(1'b1);

        // Idle: ALU driven to zero, no readies, buffer drains and holds data
        #1;
        checkOutput("idle alu_in1", bus.alu_in1, 16'h0);
        checkOutput("idle alu_in2", bus.alu_in2, 16'h0);
        checkOutput("idle alu_op", bus.alu_op, 16'h0);
        checkOutput("idle alu_shift", bus.alu_shift, 16'h0);
        checkOutput("idle req0_ready", bus.req0_ready, 16'h0);
        checkOutput("idle req1_ready", bus.req1_ready, 16'h0);
        @(posedge clk); #1;
        checkOutput("drain res_valid", bus.res_valid, 16'h0);
        checkOutput("drain res_data", bus.res_data, 16'h3333);
        checkOutput("drain res_id", bus.res_id, 16'h1);

        // A requester that withdraws before acceptance keeps no turn
        applyStimulus(1'b0, 3'd0, 16'h0001, 16'h0001, 4'd0, 1'b0);
        @(posedge clk); #1;
        checkOutput("turn fill res_data", bus.res_data, 16'h0002);
        clearReq(1'b0);
        bus.res_ready = 1'b0;
        applyStimulus(1'b1, 3'd0, 16'h0005, 16'h0000, 4'd0, 1'b0);
        #1;
        checkOutput("turn stalled req1_ready", bus.req1_ready, 16'h0);
        @(posedge clk); #1;
        clearReq(1'b1);
        @(posedge clk); #1;
        applyStimulus(1'b0, 3'd0, 16'h0010, 16'h0000, 4'd0, 1'b0);
        applyStimulus(1'b1, 3'd0, 16'h0020, 16'h0000, 4'd0, 1'b0);
        bus.res_ready = 1'b1;
        #1;
        checkOutput("turn tie req1_ready", bus.req1_ready, 16'h1);
        checkOutput("turn tie req0_ready", bus.req0_ready, 16'h0);
        @(posedge clk); #1;
        checkOutput("turn tie res_data", bus.res_data, 16'h0020);
        clearReq(1'b0);
        clearReq(1'b1);

        // Asynchronous reset with a result pending and NZP non-default
        applyStimulus(1'b0, 3'd0, 16'h8000, 16'h0000, 4'd0, 1'b1);
        @(posedge clk); #1;
        checkOutput("prerst nzp", bus.nzp, 16'h4);
        checkOutput("prerst res_valid", bus.res_valid, 16'h1);
        clearReq(1'b0);
        bus.res_ready = 1'b0;
        #2 reset = 1'b0;
        #1;
        checkOutput("rst res_valid", bus.res_valid, 16'h0);
        checkOutput("rst nzp", bus.nzp, 16'h2);
        checkOutput("rst res_data", bus.res_data, 16'h0);
        checkOutput("rst res_id", bus.res_id, 16'h0);
        #2 reset = 1'b1;
        @(posedge clk); #1;
        // Round-robin pointer restarts so requester 0 wins the first tie
        bus.res_ready = 1'b1;
        applyStimulus(1'b0, 3'd0, 16'h0040, 16'h0000, 4'd0, 1'b0);
        applyStimulus(1'b1, 3'd0, 16'h0080, 16'h0000, 4'd0, 1'b0);
        #1;
        checkOutput("postrst req0_ready", bus.req0_ready, 16'h1);
        checkOutput("postrst req1_ready", bus.req1_ready, 16'h0);
        @(posedge clk); #1;
        checkOutput("postrst res_id", bus.res_id, 16'h0);
        checkOutput("postrst res_data", bus.res_data, 16'h0040);
        clearReq(1'b0);
        clearReq(1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
